blake2_stream_ctrl: RTL and testbench

Sequencer between a 64-bit word stream source and the BLAKE2 hashing core (core command interface: init/next/final, 1024-bit block, 128-bit length, ready, digest_valid, digest).
- Packs incoming words into 1024-bit blocks and keeps a running byte count.
- Issues one core command per block, marking the last block final.
- Captures the digest and presents it to the host on a valid/ready handshake.

---
 rtl/blake2_ctrl_pkg.sv | 12 +
 rtl/blake2_block_packer.sv | 58 +++++
 rtl/blake2_stream_ctrl.sv | 80 ++++++++
 tb/tb_blake2_stream_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2_ctrl_pkg.sv
// blake2_ctrl_pkg: shared constants, controller states and the last-word byte-keep mask
package blake2_ctrl_pkg;
  localparam int WORD_W = 64;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int BLOCK_W = WORD_W * WORDS_PER_BLOCK;
  localparam int LEN_W = 128;
  localparam int DIGEST_W = 88;
  typedef enum logic [2:0] {IDLE, START, FILL, ISSUE, WAIT_RDY, WAIT_DGST, OUT} state_t;
  function automatic logic [WORD_W-1:0] byte_mask(input logic [3:0] n);
    return ~({WORD_W{1'b1}} << {n, 3'b000});
  endfunction
endpackage

// File: rtl/blake2_block_packer.sv
// blake2_block_packer: slots stream words into a block, masks the last word, keeps the hold word and byte count
module blake2_block_packer
  import blake2_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               acc,
  input  logic               shift,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_last,
  input  logic [3:0]         s_bytes,
  output logic [BLOCK_W-1:0] block,
  output logic [4:0]         cnt,
  output logic               fin,
  output logic [LEN_W-1:0]   len
);
  logic [WORD_W-1:0] hold;
  logic              hold_last;
  logic [3:0]        nb;
  logic [WORD_W-1:0] w;
  always_comb begin
    nb = (!s_last || (s_bytes == 4'd0 && cnt != 5'd0)) ? 4'd8 : s_bytes;
    w = s_data & byte_mask(nb);
  end
  // a word arriving with 16 slots full parks in hold until the block is issued
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      block <= '0;
      cnt <= '0;
      fin <= 1'b0;
      len <= '0;
      hold <= '0;
      hold_last <= 1'b0;
    end else if (clr) begin
      block <= '0;
      cnt <= '0;
      fin <= 1'b0;
      len <= '0;
      hold <= '0;
      hold_last <= 1'b0;
    end else if (shift) begin
      block <= BLOCK_W'(hold);
      cnt <= 5'd1;
      fin <= hold_last;
      hold_last <= 1'b0;
    end else if (acc) begin
      len <= len + LEN_W'(nb);
      if (cnt[4]) begin
        hold <= w;
        hold_last <= s_last;
      end else begin
        block[{cnt[3:0], 6'd0} +: WORD_W] <= w;
        cnt <= cnt + 5'd1;
        fin <= s_last;
      end
    end
endmodule

// File: rtl/blake2_stream_ctrl.sv
// blake2_stream_ctrl: sequences a 64-bit word stream into BLAKE2 core commands and hands back the digest
module blake2_stream_ctrl
  import blake2_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WORD_W-1:0]   s_data,
  input  logic                s_valid,
  input  logic                s_last,
  input  logic [3:0]          s_bytes,
  output logic                s_ready,
  output logic                core_init,
  output logic                core_next,
  output logic                core_final,
  output logic [BLOCK_W-1:0]  core_block,
  output logic [LEN_W-1:0]    core_length,
  input  logic                core_ready,
  input  logic                core_digest_valid,
  input  logic [DIGEST_W-1:0] core_digest,
  output logic [DIGEST_W-1:0] dgst,
  output logic                dgst_valid,
  input  logic                dgst_ready,
  output logic                busy
);
  state_t     state, nxt;
  logic [4:0] cnt;
  logic       fin;
  logic       acc;
  logic       shift;
  blake2_block_packer u_pack (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state == IDLE),
    .acc     (acc),
    .shift   (shift),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_bytes (s_bytes),
    .block   (core_block),
    .cnt     (cnt),
    .fin     (fin),
    .len     (core_length)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) dgst <= '0;
    else if (state == WAIT_DGST && core_digest_valid) dgst <= core_digest;
  always_comb begin
    nxt = state;
    core_init = 1'b0;
    core_next = 1'b0;
    core_final = 1'b0;
    s_ready = state == FILL;
    acc = s_valid && s_ready;
    shift = 1'b0;
    case (state)
      IDLE:      nxt = s_valid ? START : IDLE;
      START: begin
        core_init = core_ready;
        nxt = core_ready ? FILL : START;
      end
      FILL:      nxt = (acc && (cnt[4] || s_last)) ? ISSUE : FILL;
      ISSUE: begin
        core_next = core_ready && !fin;
        core_final = core_ready && fin;
        shift = core_next;
        nxt = core_final ? WAIT_DGST : core_next ? WAIT_RDY : ISSUE;
      end
      // one cycle of ignoring core_ready after a pulse; a last hold word goes straight back to issue
      WAIT_RDY:  nxt = fin ? ISSUE : FILL;
      WAIT_DGST: nxt = core_digest_valid ? OUT : WAIT_DGST;
      OUT:       nxt = dgst_ready ? IDLE : OUT;
      default:   nxt = IDLE;
    endcase
  end
  assign dgst_valid = state == OUT;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_blake2_stream_ctrl.sv
// tb_blake2_stream_ctrl: table-driven messages against a scoreboarded core model and host
module tb_blake2_stream_ctrl;
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [63:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [3:0]    s_bytes = '0;
  logic          s_ready;
  logic          core_init, core_next, core_final;
  logic [1023:0] core_block;
  logic [127:0]  core_length;
  logic          core_ready = 1'b1;
  logic          core_digest_valid = 1'b0;
  logic [87:0]   core_digest = '0;
  logic [87:0]   dgst;
  logic          dgst_valid;
  logic          dgst_ready = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  blake2_stream_ctrl dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_bytes(s_bytes), .s_ready(s_ready), .core_init(core_init), .core_next(core_next),
    .core_final(core_final), .core_block(core_block), .core_length(core_length),
    .core_ready(core_ready), .core_digest_valid(core_digest_valid), .core_digest(core_digest),
    .dgst(dgst), .dgst_valid(dgst_valid), .dgst_ready(dgst_ready), .busy(busy)
  );

  typedef struct { int kind; logic [1023:0] blk; logic [127:0] len; } cmd_t;
  typedef struct { int n; int pat; bit zero8; bit stall; int dhold; int exp_nexts; } row_t;
  localparam logic [87:0] H0 = 88'h0123456789abcdef012345;

  cmd_t        q[$];
  logic [87:0] dq[$];
  row_t        tbl[9];
  byte unsigned msg[512];
  int cmp = 0, err = 0, nexts = 0, pulses = 0, cyc = 0, stall_until = 0, gap = 0, dvc = 0;
  logic        cmd_seen = 1'b0, fin_seen = 1'b0, dv_prev = 1'b0, prev_v = 1'b0;
  logic [87:0] prev_d = '0, h = '0, h_out = '0;
  cmd_t        ma, me;
  int          dw;

  function automatic logic [87:0] fold(input logic [87:0] h0, input logic [1023:0] b);
    logic [87:0] r;
    r = h0;
    for (int i = 0; i < 16; i++) r = {r[80:0], r[87:81]} ^ {24'd0, b[i*64 +: 64]};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    cmp++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // monitor: command scoreboard, digest scoreboard, stability and latency checks
  initial forever begin
    @(negedge clk);
    if (core_init || core_next || core_final) begin
      pulses++;
      ma.kind = core_init ? 0 : core_next ? 1 : 2;
      ma.blk = core_block;
      ma.len = core_length;
      chk("one_pulse", 128'($onehot({core_init, core_next, core_final})), 128'd1);
      chk("pulse_ready", 128'(core_ready), 128'd1);
      cmp++;
      if (q.size() == 0) begin
        err++;
        $display("FAIL unexpected_cmd: got kind %0d, expected no command", ma.kind);
      end else begin
        me = q.pop_front();
        if (ma.kind != me.kind || (me.kind != 0 && ma.blk !== me.blk) || (me.kind == 2 && ma.len !== me.len)) begin
          err++;
          dw = 0;
          for (int i = 15; i >= 0; i--) if (ma.blk[i*64 +: 64] !== me.blk[i*64 +: 64]) dw = i;
          $display("FAIL cmd: got kind=%0d len=%0d word%0d=%h, expected kind=%0d len=%0d word%0d=%h",
                   ma.kind, ma.len, dw, ma.blk[dw*64 +: 64], me.kind, me.len, dw, me.blk[dw*64 +: 64]);
        end
      end
      if (ma.kind == 0) h = H0;
      else h = fold(h, ma.blk);
      if (ma.kind == 2) h_out = h ^ ma.len[87:0];
      if (ma.kind == 1) nexts++;
    end
    cmd_seen = core_init || core_next || core_final;
    fin_seen = core_final;
    if (dv_prev) chk("dgst_latency", 128'(dgst_valid), 128'd1);
    dv_prev = core_digest_valid;
    if (dgst_valid && prev_v) chk("dgst_stable", 128'(dgst), 128'(prev_d));
    if (dgst_valid && dgst_ready) begin
      if (dq.size() == 0) chk("dgst_expected", 128'd0, 128'd1);
      else chk("dgst", 128'(dgst), 128'(dq.pop_front()));
    end
    prev_v = dgst_valid && !dgst_ready;
    prev_d = dgst;
  end

  // core model: ready low 2 cycles after each command or while stalled, digest 4 cycles after final
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    core_digest_valid = 1'b0;
    if (!reset_n) begin
      gap = 0;
      dvc = 0;
    end else begin
      if (cmd_seen) gap = 2;
      else if (gap > 0) gap--;
      if (fin_seen) dvc = 3;
      else if (dvc > 0) begin
        dvc--;
        if (dvc == 0) begin
          core_digest_valid = 1'b1;
          core_digest = h_out;
        end
      end
    end
    core_ready = gap == 0 && cyc >= stall_until;
  end

  task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] b, output int wt);
    s_data = d;
    s_valid = 1'b1;
    s_last = l;
    s_bytes = b;
    wt = 0;
    while (!s_ready && wt < 400) begin
      @(posedge clk);
      #1;
      wt++;
    end
    if (wt >= 400) chk("s_ready_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] word_of(input int w, input int n);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[j*8 +: 8] = (w*8 + j < n) ? msg[w*8 + j] : 8'hEE;
    return d;
  endfunction

  task automatic run_msg(input row_t r);
    cmd_t        c;
    logic [87:0] hh;
    int          nw, nb, rem, n0, wt;
    n0 = nexts;
    for (int i = 0; i < r.n; i++) msg[i] = r.pat == 1 ? 8'(8'h61 + i) : 8'($urandom);
    if (r.pat == 2) msg[r.n-1] = 8'hAA;
    nw = r.n == 0 ? 1 : (r.n + 7) / 8;
    nb = (nw + 15) / 16;
    c.kind = 0; c.blk = '0; c.len = '0;
    q.push_back(c);
    hh = H0;
    for (int k = 0; k < nb; k++) begin
      c.blk = '0;
      for (int i = k*128; i < r.n && i < (k+1)*128; i++) c.blk[(i - k*128)*8 +: 8] = msg[i];
      c.kind = k == nb - 1 ? 2 : 1;
      c.len = 128'(r.n);
      q.push_back(c);
      hh = fold(hh, c.blk);
    end
    dq.push_back(hh ^ 88'(r.n));
    rem = r.n - 8*(nw - 1);
    if (rem == 8 && r.zero8) rem = 0;
    for (int w = 0; w < nw; w++) begin
      if (r.stall && w == 15) stall_until = cyc + 10;
      send_word(word_of(w, r.n), w == nw - 1, w == nw - 1 ? 4'(rem) : 4'd8, wt);
      if (r.stall && w == 17) chk("stall_backpressure", 128'(wt >= 6), 128'd1);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    wt = 0;
    while (!dgst_valid && wt < 1000) begin
      @(posedge clk);
      #1;
      wt++;
    end
    chk("dgst_valid_seen", 128'(dgst_valid), 128'd1);
    repeat (r.dhold) begin
      @(posedge clk);
      #1;
    end
    dgst_ready = 1'b1;
    @(posedge clk);
    #1;
    dgst_ready = 1'b0;
    chk("idle_after", 128'(busy), 128'd0);
    chk("next_count", 128'(nexts - n0), 128'(r.exp_nexts));
    chk("queues_empty", 128'(q.size() + dq.size()), 128'd0);
  endtask

  initial begin
    cmd_t c;
    int   wt, p0;
    tbl[0] = '{3, 1, 0, 0, 0, 0};
    tbl[1] = '{128, 0, 0, 0, 2, 0};
    tbl[2] = '{129, 2, 0, 0, 0, 1};
    tbl[3] = '{0, 0, 0, 0, 1, 0};
    tbl[4] = '{300, 0, 0, 1, 5, 2};
    tbl[5] = '{64, 0, 1, 0, 0, 0};
    tbl[6] = '{136, 0, 1, 0, 3, 1};
    tbl[7] = '{256, 0, 0, 0, 0, 1};
    tbl[8] = '{1, 0, 0, 0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 128'({s_ready, core_init, core_next, core_final, dgst_valid, busy,
                             |core_block, |core_length, |dgst}), 128'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) run_msg(tbl[i]);
    for (int i = 0; i < 160; i++) msg[i] = 8'($urandom);
    c.kind = 0; c.blk = '0; c.len = '0;
    q.push_back(c);
    for (int i = 0; i < 128; i++) c.blk[i*8 +: 8] = msg[i];
    c.kind = 1;
    q.push_back(c);
    for (int w = 0; w < 20; w++) send_word(word_of(w, 160), 1'b0, 4'd8, wt);
    s_valid = 1'b0;
    wt = 0;
    while (q.size() != 0 && wt < 200) begin
      @(posedge clk);
      #1;
      wt++;
    end
    chk("abort_issued", 128'(q.size()), 128'd0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_outputs", 128'({s_ready, core_init, core_next, core_final, dgst_valid, busy,
                               |core_block, |core_length, |dgst}), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    p0 = pulses;
    repeat (30) begin
      @(posedge clk);
      #1;
    end
    chk("no_cmd_after_reset", 128'(pulses - p0), 128'd0);
    chk("idle_after_reset", 128'(busy), 128'd0);
    run_msg(tbl[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
